// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - MIPS-style control pipeline: ID decode, EX/MEM/WB control bundles, load-use stall, syscall drain
module ctrl_pipe #(
  parameter int MEM_STAGES = 1,
  parameter int HAZARD_EN  = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        stall_in,
  input  logic        flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic        mem_valid,
  output logic        wb_valid,
  output logic [18:0] ex_ctrl,
  output logic [18:0] mem_ctrl,
  output logic [18:0] wb_ctrl,
  output logic [4:0]  wb_dst,
  output logic        halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BLTZ  = 6'h01, OP_J     = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_BLT   = 6'h06, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SB    = 6'h28, OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRA = 6'h03, F_JR  = 6'h08, F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25, F_SLT = 6'h2A;

  localparam int B_RW = 18, B_M2R = 17, B_MRD = 16, B_MWR = 15, B_MSB = 14, B_BR = 13;
  localparam int B_BNE = 12, B_BLT = 11, B_JMP = 10, B_JR = 9, B_JAL = 8, B_RDST = 7;
  localparam int B_ASRC = 6, B_SYS = 0;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011, ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd;
  logic [18:0] id_ctrl;
  logic [4:0]  id_dst;
  logic        unused_shamt;

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign func         = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    id_ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          F_ADD, F_ADDU: begin id_ctrl[B_RW] = 1'b1; id_ctrl[B_RDST] = 1'b1; id_ctrl[5:3] = ALU_ADD; end
          F_SUB:  begin id_ctrl[B_RW] = 1'b1; id_ctrl[B_RDST] = 1'b1; id_ctrl[5:3] = ALU_SUB; end
          F_AND:  begin id_ctrl[B_RW] = 1'b1; id_ctrl[B_RDST] = 1'b1; id_ctrl[5:3] = ALU_AND; end
          F_OR:   begin id_ctrl[B_RW] = 1'b1; id_ctrl[B_RDST] = 1'b1; id_ctrl[5:3] = ALU_OR;  end
          F_SLT:  begin id_ctrl[B_RW] = 1'b1; id_ctrl[B_RDST] = 1'b1; id_ctrl[5:3] = ALU_SLT; end
          F_SLL:  begin id_ctrl[B_RW] = 1'b1; id_ctrl[B_RDST] = 1'b1; id_ctrl[2:1] = 2'b10; end
          F_SRA:  begin id_ctrl[B_RW] = 1'b1; id_ctrl[B_RDST] = 1'b1; id_ctrl[2:1] = 2'b01; end
          F_JR:      id_ctrl[B_JR]  = 1'b1;
          F_SYSCALL: id_ctrl[B_SYS] = 1'b1;
          default:   id_ctrl = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin id_ctrl[B_RW] = 1'b1; id_ctrl[B_ASRC] = 1'b1; id_ctrl[5:3] = ALU_ADD; end
      OP_ANDI: begin id_ctrl[B_RW] = 1'b1; id_ctrl[B_ASRC] = 1'b1; id_ctrl[5:3] = ALU_AND; end
      OP_ORI:  begin id_ctrl[B_RW] = 1'b1; id_ctrl[B_ASRC] = 1'b1; id_ctrl[5:3] = ALU_OR;  end
      OP_LUI:  begin id_ctrl[B_RW] = 1'b1; id_ctrl[B_ASRC] = 1'b1; id_ctrl[5:3] = ALU_LUI; end
      OP_LW: begin
        id_ctrl[B_RW] = 1'b1; id_ctrl[B_M2R] = 1'b1; id_ctrl[B_MRD] = 1'b1;
        id_ctrl[B_ASRC] = 1'b1; id_ctrl[5:3] = ALU_ADD;
      end
      OP_SW: begin id_ctrl[B_MWR] = 1'b1; id_ctrl[B_ASRC] = 1'b1; id_ctrl[5:3] = ALU_ADD; end
      OP_SB: begin
        id_ctrl[B_MWR] = 1'b1; id_ctrl[B_MSB] = 1'b1; id_ctrl[B_ASRC] = 1'b1; id_ctrl[5:3] = ALU_ADD;
      end
      OP_BEQ:  begin id_ctrl[B_BR] = 1'b1; id_ctrl[5:3] = ALU_SUB; end
      OP_BNE:  begin id_ctrl[B_BR] = 1'b1; id_ctrl[B_BNE] = 1'b1; id_ctrl[5:3] = ALU_SUB; end
      OP_BLT, OP_BLTZ: begin id_ctrl[B_BR] = 1'b1; id_ctrl[B_BLT] = 1'b1; id_ctrl[5:3] = ALU_SUB; end
      OP_J:    id_ctrl[B_JMP] = 1'b1;
      OP_JAL:  begin id_ctrl[B_JMP] = 1'b1; id_ctrl[B_JAL] = 1'b1; id_ctrl[B_RW] = 1'b1; end
      default: id_ctrl = '0;
    endcase
  end

  assign id_dst = id_ctrl[B_JAL] ? 5'd31 : (id_ctrl[B_RDST] ? rd : rt);

  state_t                           state_q, state_d;
  logic                             halted_q, halted_d;
  logic                             ex_valid_q, ex_valid_d, wb_valid_q, wb_valid_d;
  logic [18:0]                      ex_ctrl_q, ex_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic [4:0]                       ex_dst_q, ex_dst_d, wb_dst_q, wb_dst_d;
  logic [MEM_STAGES-1:0]            mem_valid_q, mem_valid_d;
  logic [MEM_STAGES-1:0][18:0]      mem_ctrl_q, mem_ctrl_d;
  logic [MEM_STAGES-1:0][4:0]       mem_dst_q, mem_dst_d;
  logic                             load_use, sys_id, drained, issue, stall_c;

  assign load_use = (HAZARD_EN != 0) && instr_valid && ex_valid_q && ex_ctrl_q[B_MRD] &&
                    (ex_dst_q != 5'd0) && ((ex_dst_q == rs) || (ex_dst_q == rt));
  assign sys_id   = instr_valid && id_ctrl[B_SYS];
  assign drained  = !ex_valid_q && !(|mem_valid_q) && !wb_valid_q;

  // Stall has priority: no state transition or capture happens while stall_in is high.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    issue    = 1'b0;
    stall_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush && !stall_in) begin
          issue = 1'b0;
        end else if (sys_id) begin
          stall_c = 1'b1;
          if (!stall_in) state_d = ST_DRAIN;
        end else if (load_use) begin
          stall_c = 1'b1;
        end else begin
          issue = instr_valid;
        end
      end
      ST_DRAIN: begin
        if (flush && !stall_in) begin
          state_d = ST_RUN;
        end else begin
          stall_c = 1'b1;
          if (!stall_in && drained) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end
      end
      default: stall_c = 1'b1;
    endcase
  end

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_dst_d    = ex_dst_q;
    mem_valid_d = mem_valid_q;
    mem_ctrl_d  = mem_ctrl_q;
    mem_dst_d   = mem_dst_q;
    wb_valid_d  = wb_valid_q;
    wb_ctrl_d   = wb_ctrl_q;
    wb_dst_d    = wb_dst_q;
    if (!stall_in) begin
      ex_valid_d     = issue;
      ex_ctrl_d      = issue ? id_ctrl : 19'd0;
      ex_dst_d       = issue ? id_dst : 5'd0;
      mem_valid_d[0] = ex_valid_q;
      mem_ctrl_d[0]  = ex_ctrl_q;
      mem_dst_d[0]   = ex_dst_q;
      for (int i = 1; i < MEM_STAGES; i++) begin
        mem_valid_d[i] = mem_valid_q[i-1];
        mem_ctrl_d[i]  = mem_ctrl_q[i-1];
        mem_dst_d[i]   = mem_dst_q[i-1];
      end
      wb_valid_d = mem_valid_q[MEM_STAGES-1];
      wb_ctrl_d  = mem_ctrl_q[MEM_STAGES-1];
      wb_dst_d   = mem_dst_q[MEM_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_RUN;
      halted_q    <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_dst_q    <= '0;
      mem_valid_q <= '0;
      mem_ctrl_q  <= '0;
      mem_dst_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_dst_q    <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_dst_q    <= ex_dst_d;
      mem_valid_q <= mem_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_dst_q   <= mem_dst_d;
      wb_valid_q  <= wb_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_dst_q    <= wb_dst_d;
    end
  end

  assign id_stall  = rst_b & stall_c;
  assign halted    = halted_q;
  assign ex_valid  = ex_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign mem_valid = mem_valid_q[MEM_STAGES-1];
  assign mem_ctrl  = mem_ctrl_q[MEM_STAGES-1];
  assign wb_valid  = wb_valid_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign wb_dst    = wb_dst_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed bench for ctrl_pipe (MEM_STAGES=1 and MEM_STAGES=3 instances)
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;

  logic        id_stall, ex_valid, mem_valid, wb_valid, halted;
  logic [18:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  wb_dst;
  logic        id_stall3, ex_valid3, mem_valid3, wb_valid3, halted3;
  logic [18:0] ex_ctrl3, mem_ctrl3, wb_ctrl3;
  logic [4:0]  wb_dst3;

  int total = 0;
  int bad = 0;

  localparam logic [18:0] C_ADD = 19'h40090, C_OR = 19'h40088, C_SUB = 19'h400B0;
  localparam logic [18:0] C_LW = 19'h70050, C_SW = 19'h08050, C_BEQ = 19'h02030;
  localparam logic [18:0] C_JAL = 19'h40500, C_SLL = 19'h40084;

  ctrl_pipe #(.MEM_STAGES(1), .HAZARD_EN(1)) u1 (
    .clk(clk), .rst_b(rst_b), .instr_valid(instr_valid), .instr(instr),
    .stall_in(stall_in), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .wb_dst(wb_dst), .halted(halted)
  );

  ctrl_pipe #(.MEM_STAGES(3), .HAZARD_EN(1)) u3 (
    .clk(clk), .rst_b(rst_b), .instr_valid(instr_valid), .instr(instr),
    .stall_in(stall_in), .flush(flush), .id_stall(id_stall3),
    .ex_valid(ex_valid3), .mem_valid(mem_valid3), .wb_valid(wb_valid3),
    .ex_ctrl(ex_ctrl3), .mem_ctrl(mem_ctrl3), .wb_ctrl(wb_ctrl3),
    .wb_dst(wb_dst3), .halted(halted3)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  localparam logic [31:0] SYSCALL = 32'h0000_000C;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    instr = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    tick();
    tick();
    total++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin bad++; $display("FAIL reset_valids got=%b exp=000", {ex_valid, mem_valid, wb_valid}); end
    total++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 57'd0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", {ex_ctrl, mem_ctrl, wb_ctrl}); end
    total++; if ({wb_dst, id_stall, halted} !== 7'd0) begin bad++; $display("FAIL reset_misc got=%b exp=0", {wb_dst, id_stall, halted}); end
    total++; if ({ex_valid3, mem_valid3, wb_valid3, halted3} !== 4'd0) begin bad++; $display("FAIL reset_u3 got=%b exp=0", {ex_valid3, mem_valid3, wb_valid3, halted3}); end
    rst_b = 1'b1;
  endtask

  task automatic test_add();
    idle(2);
    instr_valid = 1'b1;
    instr = r_type(5'd1, 5'd2, 5'd3, 6'h20);
    tick();
    total++; if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD) begin bad++; $display("FAIL add_ex got=%b/%h exp=1/%h", ex_valid, ex_ctrl, C_ADD); end
    instr_valid = 1'b0;
    tick();
    total++; if (mem_valid !== 1'b1 || mem_ctrl !== C_ADD) begin bad++; $display("FAIL add_mem got=%b/%h exp=1/%h", mem_valid, mem_ctrl, C_ADD); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_dst !== 5'd3 || wb_ctrl !== C_ADD) begin bad++; $display("FAIL add_wb got=%b/%0d/%h exp=1/3/%h", wb_valid, wb_dst, wb_ctrl, C_ADD); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL add_wb_empty got=%b exp=0", wb_valid); end
  endtask

  task automatic test_decode_back_to_back();
    logic [31:0] ti [8];
    logic [18:0] tc [8];
    logic [4:0]  td [8];
    ti[0] = r_type(5'd1, 5'd2, 5'd7, 6'h25);   tc[0] = C_OR;   td[0] = 5'd7;
    ti[1] = r_type(5'd3, 5'd4, 5'd8, 6'h22);   tc[1] = C_SUB;  td[1] = 5'd8;
    ti[2] = i_type(6'h2B, 5'd1, 5'd9);         tc[2] = C_SW;   td[2] = 5'd9;
    ti[3] = i_type(6'h04, 5'd1, 5'd2);         tc[3] = C_BEQ;  td[3] = 5'd2;
    ti[4] = {6'h03, 26'h10};                   tc[4] = C_JAL;  td[4] = 5'd31;
    ti[5] = r_type(5'd0, 5'd11, 5'd10, 6'h00); tc[5] = C_SLL;  td[5] = 5'd10;
    ti[6] = r_type(5'd1, 5'd2, 5'd12, 6'h3F);  tc[6] = 19'd0;  td[6] = 5'd2;
    ti[7] = i_type(6'h23, 5'd1, 5'd13);        tc[7] = C_LW;   td[7] = 5'd13;
    idle(3);
    for (int i = 0; i < 8; i++) begin
      instr_valid = 1'b1;
      instr = ti[i];
      tick();
      total++; if (ex_valid !== 1'b1 || ex_ctrl !== tc[i]) begin bad++; $display("FAIL decode_ex[%0d] got=%b/%h exp=1/%h", i, ex_valid, ex_ctrl, tc[i]); end
      if (i >= 2) begin
        total++; if (wb_valid !== 1'b1 || wb_dst !== td[i-2] || wb_ctrl !== tc[i-2]) begin bad++; $display("FAIL decode_wb[%0d] got=%b/%0d/%h exp=1/%0d/%h", i-2, wb_valid, wb_dst, wb_ctrl, td[i-2], tc[i-2]); end
      end
    end
    for (int i = 6; i < 8; i++) begin
      idle(1);
      total++; if (wb_valid !== 1'b1 || wb_dst !== td[i] || wb_ctrl !== tc[i]) begin bad++; $display("FAIL decode_wb[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, wb_valid, wb_dst, wb_ctrl, td[i], tc[i]); end
    end
  endtask

  task automatic test_load_use();
    idle(3);
    instr_valid = 1'b1;
    instr = i_type(6'h23, 5'd1, 5'd5);
    tick();
    instr = r_type(5'd5, 5'd2, 5'd6, 6'h20);
    #1;
    total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", id_stall); end
    tick();
    total++; if (ex_valid !== 1'b0 || ex_ctrl !== 19'd0) begin bad++; $display("FAIL lu_bubble got=%b/%h exp=0/0", ex_valid, ex_ctrl); end
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%b exp=0", id_stall); end
    tick();
    total++; if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD) begin bad++; $display("FAIL lu_add_ex got=%b/%h exp=1/%h", ex_valid, ex_ctrl, C_ADD); end
    total++; if (mem_valid !== 1'b0 || wb_valid !== 1'b1 || wb_dst !== 5'd5) begin bad++; $display("FAIL lu_gap got=%b/%b/%0d exp=0/1/5", mem_valid, wb_valid, wb_dst); end
    instr = i_type(6'h23, 5'd1, 5'd0);
    tick();
    instr = r_type(5'd0, 5'd2, 5'd6, 6'h20);
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL lu_r0 got=%b exp=0", id_stall); end
    idle(4);
  endtask

  task automatic test_flush();
    instr_valid = 1'b1;
    instr = i_type(6'h23, 5'd1, 5'd5);
    tick();
    instr = r_type(5'd5, 5'd2, 5'd6, 6'h20);
    flush = 1'b1;
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", id_stall); end
    tick();
    flush = 1'b0;
    total++; if (ex_valid !== 1'b0 || mem_valid !== 1'b1 || mem_ctrl !== C_LW) begin bad++; $display("FAIL flush_bubble got=%b/%b/%h exp=0/1/%h", ex_valid, mem_valid, mem_ctrl, C_LW); end
    idle(4);
  endtask

  task automatic test_stall();
    instr_valid = 1'b1;
    instr = r_type(5'd2, 5'd3, 5'd1, 6'h20);
    tick();
    instr = r_type(5'd3, 5'd4, 5'd2, 6'h25);
    tick();
    instr = r_type(5'd4, 5'd5, 5'd3, 6'h22);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      tick();
      total++; if (ex_valid !== 1'b1 || ex_ctrl !== C_OR || mem_valid !== 1'b1 || mem_ctrl !== C_ADD || wb_valid !== 1'b0 || wb_dst !== 5'd0) begin
        bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%b/%h/%b/%0d exp=1/%h/1/%h/0/0", i, ex_valid, ex_ctrl, mem_valid, mem_ctrl, wb_valid, wb_dst, C_OR, C_ADD);
      end
    end
    flush = 1'b0;
    stall_in = 1'b0;
    tick();
    total++; if (ex_ctrl !== C_SUB || wb_valid !== 1'b1 || wb_dst !== 5'd1) begin bad++; $display("FAIL stall_resume got=%h/%b/%0d exp=%h/1/1", ex_ctrl, wb_valid, wb_dst, C_SUB); end
    instr_valid = 1'b0;
    tick();
    total++; if (wb_valid !== 1'b1 || wb_dst !== 5'd2) begin bad++; $display("FAIL stall_wb2 got=%b/%0d exp=1/2", wb_valid, wb_dst); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_dst !== 5'd3) begin bad++; $display("FAIL stall_wb3 got=%b/%0d exp=1/3", wb_valid, wb_dst); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL stall_nodup got=%b exp=0", wb_valid); end
  endtask

  task automatic test_syscall_drain();
    idle(2);
    instr_valid = 1'b1;
    instr = r_type(5'd2, 5'd3, 5'd1, 6'h20);
    tick();
    instr = r_type(5'd2, 5'd3, 5'd2, 6'h20);
    tick();
    instr = SYSCALL;
    #1;
    total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL sys_stall got=%b exp=1", id_stall); end
    tick();
    total++; if (halted !== 1'b0 || ex_valid !== 1'b0 || mem_valid !== 1'b1) begin bad++; $display("FAIL drain1 got=%b/%b/%b exp=0/0/1", halted, ex_valid, mem_valid); end
    tick();
    total++; if (halted !== 1'b0 || wb_valid !== 1'b1 || wb_dst !== 5'd2) begin bad++; $display("FAIL drain2 got=%b/%b/%0d exp=0/1/2", halted, wb_valid, wb_dst); end
    tick();
    total++; if (halted !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL drain3 got=%b/%b exp=0/0", halted, wb_valid); end
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_enter got=%b exp=1", halted); end
    instr = r_type(5'd2, 5'd3, 5'd4, 6'h20);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (halted !== 1'b1 || id_stall !== 1'b1 || ex_valid !== 1'b0) begin bad++; $display("FAIL halt_hold[%0d] got=%b/%b/%b exp=1/1/0", i, halted, id_stall, ex_valid); end
    end
    instr_valid = 1'b0;
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_reset got=%b exp=0", halted); end
  endtask

  task automatic test_drain_flush();
    idle(2);
    instr_valid = 1'b1;
    instr = r_type(5'd2, 5'd3, 5'd1, 6'h20);
    tick();
    instr = SYSCALL;
    tick();
    flush = 1'b1;
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL dflush_stall got=%b exp=0", id_stall); end
    tick();
    flush = 1'b0;
    total++; if (ex_valid !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL dflush_bubble got=%b/%b exp=0/0", ex_valid, halted); end
    instr = r_type(5'd1, 5'd2, 5'd4, 6'h20);
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL dflush_run got=%b exp=0", id_stall); end
    tick();
    total++; if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD) begin bad++; $display("FAIL dflush_issue got=%b/%h exp=1/%h", ex_valid, ex_ctrl, C_ADD); end
    idle(5);
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL dflush_nohalt got=%b exp=0", halted); end
  endtask

  task automatic test_reset_in_drain();
    instr_valid = 1'b1;
    instr = r_type(5'd2, 5'd3, 5'd1, 6'h20);
    tick();
    instr = SYSCALL;
    tick();
    total++; if (mem_valid !== 1'b1 || id_stall !== 1'b1) begin bad++; $display("FAIL rd_pre got=%b/%b exp=1/1", mem_valid, id_stall); end
    #2;
    rst_b = 1'b0;
    #1;
    total++; if ({ex_valid, mem_valid, wb_valid, halted, id_stall} !== 5'd0) begin bad++; $display("FAIL rd_clear got=%b exp=00000", {ex_valid, mem_valid, wb_valid, halted, id_stall}); end
    instr = r_type(5'd1, 5'd2, 5'd4, 6'h20);
    rst_b = 1'b1;
    tick();
    total++; if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD) begin bad++; $display("FAIL rd_first_edge got=%b/%h exp=1/%h", ex_valid, ex_ctrl, C_ADD); end
    idle(6);
  endtask

  task automatic test_nop_deep();
    instr_valid = 1'b1;
    instr = {6'h3F, 26'h0};
    tick();
    instr_valid = 1'b0;
    total++; if (ex_valid3 !== 1'b1 || ex_ctrl3 !== 19'd0) begin bad++; $display("FAIL nop3_ex got=%b/%h exp=1/0", ex_valid3, ex_ctrl3); end
    tick();
    tick();
    tick();
    total++; if (mem_valid3 !== 1'b1 || wb_valid3 !== 1'b0) begin bad++; $display("FAIL nop3_mem got=%b/%b exp=1/0", mem_valid3, wb_valid3); end
    tick();
    total++; if (wb_valid3 !== 1'b1 || wb_ctrl3 !== 19'd0 || wb_dst3 !== 5'd0) begin bad++; $display("FAIL nop3_wb got=%b/%h/%0d exp=1/0/0", wb_valid3, wb_ctrl3, wb_dst3); end
    tick();
    total++; if (wb_valid3 !== 1'b0) begin bad++; $display("FAIL nop3_after got=%b exp=0", wb_valid3); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode_back_to_back();
    test_load_use();
    test_flush();
    test_stall();
    test_syscall_drain();
    test_drain_flush();
    test_reset_in_drain();
    test_nop_deep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter MEM_STAGES, default 1, memory-pipeline depth between EX and WB (legal 1..3).
REQ-002 SHALL have parameter HAZARD_EN, default 1, enabling load-use stall detection when 1.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_b  in  1  async reset, active low.
REQ-004 SHALL have ports:
- instr_valid  in  1  ID-stage instruction present.
- instr  in  32  ID-stage instruction word (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], func [5:0]).
- stall_in  in  1  global memory-wait freeze.
- flush  in  1  taken branch/jump resolved in EX; kill ID.
- id_stall  out  1  hold PC and IF/ID.
- ex_valid, mem_valid, wb_valid  out  1 each  stage occupancy.
- ex_ctrl, mem_ctrl, wb_ctrl  out  19 each  control bundle per stage.
- wb_dst  out  5  WB destination register.
- halted  out  1  syscall reached, pipeline drained.
REQ-005 Bundle bit order, MSB first: regWrite, memToReg, memRead, memWrite, memWriteSB, branch, branchne, branchLT, jump, jr, jal, regDst, ALUSrc, ALUop[2:0], Shift[1:0], sys.

Function
REQ-006 Decode SHALL use mips.h opcodes. ALUop: AND/ANDI 000, OR/ORI 001, ADD/ADDU/ADDI/ADDIU/LW/SW/SB 010, LUI 011, SUB/BEQ/BNE/BLT/BLTZ 110, SLT 111. Shift: SLL 10, SRA 01, else 00.
REQ-007 Undefined opcode/func SHALL decode to an all-zero bundle with the stage valid (NOP). No X is ever driven.
REQ-008 Destination SHALL be 31 for JAL, rd when regDst=1, otherwise rt. It travels with the bundle.
REQ-009 Latency: ID at edge n appears in EX at n+1, in the last MEM stage at n+1+MEM_STAGES, and in WB at n+2+MEM_STAGES.
REQ-010 stall_in=1 SHALL freeze every stage register, the FSM and halted. It has priority over flush and the hazard logic.
REQ-011 Load-use (HAZARD_EN=1): when ex_valid, ex memRead=1, ex_dst!=0 and ex_dst equals ID rs or rt, then id_stall=1 combinationally and EX loads a bubble next edge (valid=0, bundle=0).
REQ-012 flush=1 with stall_in=0 SHALL replace the ID instruction with a bubble into EX and SHALL clear id_stall for that cycle. Older stages advance normally.
REQ-013 FSM states are RUN, DRAIN, HALT.
- RUN->DRAIN when a valid ID instruction decodes sys=1 and neither stall nor flush is active. The syscall is held in ID: id_stall=1, bubbles are issued.
REQ-014 In DRAIN:
- DRAIN->HALT once ex_valid, all MEM valids and wb_valid are 0.
- flush=1 in DRAIN SHALL return to RUN and discard the syscall.
REQ-015 HALT: halted=1, id_stall=1, bubbles only; exit only by reset.
REQ-016 Reset asserted mid-operation SHALL immediately clear all state, including a DRAIN in progress.

Reset
REQ-017 While rst_b=0: every valid=0, every bundle=0, wb_dst=0, id_stall=0, halted=0, FSM=RUN.
REQ-018 After deassertion, the first rising clk edge SHALL sample ID normally.

Verification
REQ-019 ADD r3,r1,r2 at edge 0, MEM_STAGES=1 -> ex_ctrl regWrite=1, regDst=1, ALUop=010 at edge 1; wb_valid=1 and wb_dst=3 at edge 3.
REQ-020 LW r5,0(r1) then ADD r6,r5,r2 -> id_stall=1 for exactly one cycle; ADD reaches EX one cycle late, with one bubble between.
REQ-021 stall_in=1 for 3 cycles mid-stream -> all outputs constant for those 3 cycles, then resume with no loss or duplication.
REQ-022 SYSCALL with 2 older instructions in flight -> DRAIN for 3 cycles (MEM_STAGES=1), then halted=1 persisting 10+ cycles.
REQ-023 SYSCALL in ID with flush=1 in the same DRAIN cycle -> FSM=RUN, halted stays 0, EX gets a bubble.
REQ-024 MEM_STAGES=3 and opcode 0x3F -> all-zero bundle with valid=1 at WB after 5 cycles. rst_b pulsed during DRAIN -> all valids 0 and halted=0 at once.
